// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types for the line-granular memory responder
package mem_pkg;

   localparam int BLK_DEF = 64;

   typedef logic [BLK_DEF-1:0][7:0] line_t;
   typedef logic [BLK_DEF-1:0]      strb_t;
   typedef logic [7:0]              rqst_t;

   localparam rqst_t TRSC_WB   = 8'd0;
   localparam rqst_t TRSC_GETV = 8'd1;

   typedef enum logic [1:0] {FREE, WAIT, DONE} slot_state_e;

   function automatic rqst_t make_handle(input rqst_t base, input logic [3:0] slot);
      return base | {4'b0000, slot};
   endfunction

endpackage

// File: rtl/mem_rsp_queue.sv
// rtl/mem_rsp_queue.sv - deferred-read slot table; MEM_RESPONDER_RANDLAT_EN serves DONE slots oldest first
module mem_rsp_queue
   import mem_pkg::*;
#(
   parameter int QSZ = 4,
   parameter int SW  = 2,
   parameter int CW  = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          alloc_en,
   input  rqst_t         alloc_id,
   input  logic [63:0]   alloc_addr,
   input  logic [CW-1:0] alloc_cnt,
   input  logic          rel_en,
   input  logic [SW-1:0] rel_slot,
   input  rqst_t         lookup_id,
   output logic          dup_hit,
   output logic [SW-1:0] dup_slot,
   output logic          free_vld,
   output logic [SW-1:0] free_slot,
   output logic          done_vld,
   output logic [SW-1:0] done_slot,
   output logic [63:0]   done_addr
);

   slot_state_e   st     [QSZ];
   rqst_t         id_q   [QSZ];
   logic [63:0]   addr_q [QSZ];
   logic [CW-1:0] cnt_q  [QSZ];
`ifdef MEM_RESPONDER_RANDLAT_EN
   logic [SW:0]   age_q  [QSZ];
   logic [SW:0]   best_age;
`endif

   // Scan downward so the lowest matching index is the one left standing.
   always_comb begin
      dup_hit   = 1'b0;
      dup_slot  = '0;
      free_vld  = 1'b0;
      free_slot = '0;
      done_vld  = 1'b0;
      done_slot = '0;
`ifdef MEM_RESPONDER_RANDLAT_EN
      best_age  = '0;
`endif
      for (int i = QSZ - 1; i >= 0; i--) begin
         if (st[i] == FREE) begin
            free_vld  = 1'b1;
            free_slot = SW'(i);
         end else if (id_q[i] == lookup_id) begin
            dup_hit  = 1'b1;
            dup_slot = SW'(i);
         end
`ifdef MEM_RESPONDER_RANDLAT_EN
         if (st[i] == DONE && (!done_vld || age_q[i] >= best_age)) begin
            done_vld  = 1'b1;
            done_slot = SW'(i);
            best_age  = age_q[i];
         end
`else
         if (st[i] == DONE) begin
            done_vld  = 1'b1;
            done_slot = SW'(i);
         end
`endif
      end
   end

   assign done_addr = addr_q[done_slot];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < QSZ; i++) begin
            st[i]     <= FREE;
            id_q[i]   <= '0;
            addr_q[i] <= '0;
            cnt_q[i]  <= '0;
`ifdef MEM_RESPONDER_RANDLAT_EN
            age_q[i]  <= '0;
`endif
         end
      end else begin
         for (int i = 0; i < QSZ; i++) begin
            if (rel_en && rel_slot == SW'(i)) begin
               st[i] <= FREE;
            end else if (alloc_en && free_slot == SW'(i)) begin
               st[i]     <= WAIT;
               id_q[i]   <= alloc_id;
               addr_q[i] <= alloc_addr;
               cnt_q[i]  <= alloc_cnt;
            end else if (st[i] == WAIT) begin
               // Counter reaching zero and DONE happen on the same edge; never wraps.
               if (cnt_q[i] <= CW'(1)) begin
                  cnt_q[i] <= '0;
                  st[i]    <= DONE;
               end else begin
                  cnt_q[i] <= cnt_q[i] - CW'(1);
               end
            end
`ifdef MEM_RESPONDER_RANDLAT_EN
            if (alloc_en && free_slot == SW'(i))
               age_q[i] <= '0;
            else if (alloc_en && st[i] != FREE && age_q[i] != '1)
               age_q[i] <= age_q[i] + 1'b1;
`endif
         end
      end
   end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - line store answering writes and deferred reads; MEM_RESPONDER_RANDLAT_EN adds LFSR latency jitter
module mem_responder
   import mem_pkg::*;
#(
   parameter int    BLK   = 64,
   parameter int    DEPTH = 1024,
   parameter int    QSZ   = 4,
   parameter int    LAT   = 8,
   parameter rqst_t HBASE = 8'hf0
) (
   input  logic             clk,
   input  logic             rst,
   input  rqst_t            s_rqst,
   input  logic [7:0]       s_trsc,
   input  logic [BLK-1:0]   s_strb,
   input  logic [63:0]      s_addr,
   input  logic [BLK*8-1:0] s_wdat,
   output rqst_t            s_resp,
   output logic [7:0]       s_miss,
   output logic [63:0]      s_ofst,
   output logic [BLK*8-1:0] s_rdat
);

   localparam int OFS  = $clog2(BLK);
   localparam int IDXW = $clog2(DEPTH);
   localparam int SW   = (QSZ > 1) ? $clog2(QSZ) : 1;
   localparam int CW   = $clog2(LAT + 8) + 1;
   localparam bit IMM  = (LAT == 0);

   logic [BLK*8-1:0] mem [DEPTH];

   logic          dup_hit, free_vld, done_vld;
   logic [SW-1:0] dup_slot, free_slot, done_slot;
   logic [63:0]   done_addr;
   logic [CW-1:0] alloc_cnt;
   logic [IDXW-1:0] req_idx, done_idx;
   logic          req_live, is_wr, wr_acc, rd_req, rd_hit, rd_dup, rd_alloc;

   assign req_idx  = s_addr[OFS +: IDXW];
   assign done_idx = done_addr[OFS +: IDXW];

   // A write-back with an empty strobe is acknowledged as a no-op write.
   assign is_wr    = (|s_strb) || !(s_trsc >= TRSC_GETV);
   assign req_live = rst && (s_rqst != '0) && (s_rqst != s_resp) && !done_vld;
   assign wr_acc   = req_live && is_wr;
   assign rd_req   = req_live && !is_wr;
   assign rd_hit   = rd_req && IMM;
   assign rd_dup   = rd_req && !IMM && dup_hit;
   assign rd_alloc = rd_req && !IMM && !dup_hit && free_vld;

`ifdef MEM_RESPONDER_RANDLAT_EN
   logic [15:0] lfsr;
   logic        accept;

   assign accept    = wr_acc || rd_hit || rd_dup || rd_alloc;
   assign alloc_cnt = CW'(LAT) + CW'(lfsr[2:0]);

   always_ff @(posedge clk) begin
      if (!rst)
         lfsr <= 16'hace1;
      else if (accept)
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end
`else
   assign alloc_cnt = CW'(LAT);
`endif

   mem_rsp_queue #(
      .QSZ (QSZ),
      .SW  (SW),
      .CW  (CW)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .alloc_en   (rd_alloc),
      .alloc_id   (s_rqst),
      .alloc_addr (s_addr),
      .alloc_cnt  (alloc_cnt),
      .rel_en     (done_vld),
      .rel_slot   (done_slot),
      .lookup_id  (s_rqst),
      .dup_hit    (dup_hit),
      .dup_slot   (dup_slot),
      .free_vld   (free_vld),
      .free_slot  (free_slot),
      .done_vld   (done_vld),
      .done_slot  (done_slot),
      .done_addr  (done_addr)
   );

   // The store survives reset so the requester can re-read after recovery.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         for (int b = 0; b < BLK; b++)
            if (s_strb[b])
               mem[req_idx][b*8 +: 8] <= s_wdat[b*8 +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s_resp <= '0;
         s_miss <= '0;
         s_ofst <= '0;
         s_rdat <= '0;
      end else begin
         s_resp <= '0;
         s_miss <= '0;
         s_ofst <= '0;
         s_rdat <= '0;
         if (done_vld) begin
            s_resp <= make_handle(HBASE, 4'(done_slot));
            s_ofst <= done_addr;
            s_rdat <= mem[done_idx];
         end else if (wr_acc) begin
            s_resp <= s_rqst;
            s_ofst <= s_addr;
         end else if (rd_hit) begin
            s_resp <= s_rqst;
            s_ofst <= s_addr;
            s_rdat <= mem[req_idx];
         end else if (rd_dup || rd_alloc) begin
            s_resp <= s_rqst;
            s_miss <= make_handle(HBASE, 4'(rd_dup ? dup_slot : free_slot));
            s_ofst <= s_addr;
         end
      end
   end

endmodule
